// File: rtl/accum_stage.sv
// -----------------------------------------------------------------------------
// accum_stage
//
// Sequential accumulation stage placed after the 4-bit carry adder. Operands
// arrive over a valid/ready handshake and are folded into a running 4-bit sum
// using the adder's modulo-16 addition (the carry-out is kept out of the sum).
// A result is presented after BURST_LEN operands, or earlier when in_last marks
// the final operand of a short burst. The result also carries a sticky overflow
// flag and the number of operands that were folded in.
//
// Optional feature (compile-time macro):
//   ACCUM_SATURATE_EN - on any carry-out the sum saturates to 4'hF and stays
//                       there for the rest of the burst. When undefined, the
//                       sum wraps modulo 16, matching the adder's S output.
//
// Parameters:
//   BURST_LEN  operands per result, legal range 1..15
//   CNT_W      width of the operand counter
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears all state
//   in_valid   operand present on in_data
//   in_ready   stage accepts an operand this cycle
//   in_data    4-bit operand
//   in_last    final operand of a short burst (qualified by in_valid)
//   out_valid  result present on out_*
//   out_ready  consumer takes the result this cycle
//   out_sum    accumulated sum
//   out_ovf    at least one carry-out occurred during the burst
//   out_cnt    number of operands folded into out_sum
// -----------------------------------------------------------------------------
module accum_stage #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  state_t           state;
  logic [3:0]       acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  // Holds in_ready low while rst is high and until the first clock after
  // release.
  logic             run;

  logic             accept;
  logic [4:0]       sum5;
  logic [3:0]       acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             burst_end;

  assign accept    = in_valid && in_ready;
  assign sum5      = {1'b0, acc} + {1'b0, in_data};
  assign cnt_next  = cnt + CNT_W'(1);
  assign burst_end = in_last || (cnt_next == CNT_W'(BURST_LEN));

`ifdef ACCUM_SATURATE_EN
  // Once a carry has been seen in this burst (ovf already set, or a carry
  // right now) the sum is pinned at full scale; later adds cannot lower it.
  assign acc_next = (ovf || sum5[4]) ? 4'hF : sum5[3:0];
`else
  assign acc_next = sum5[3:0];
`endif

  // NOTE: all state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
      acc   <= 4'd0;
      ovf   <= 1'b0;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        ACC: begin
          if (accept) begin
            acc <= acc_next;
            ovf <= ovf | sum5[4];
            cnt <= cnt_next;
            if (burst_end) begin
              state <= OUT;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            acc   <= 4'd0;
            ovf   <= 1'b0;
            cnt   <= '0;
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  // Outputs are pure state decode or register copies, so there is no
  // combinational path from in_* to out_* or from out_ready to in_ready.
  assign in_ready  = run && (state == ACC);
  assign out_valid = (state == OUT);
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_cnt   = cnt;

endmodule

// File: tb/tb_accum_stage.sv
// -----------------------------------------------------------------------------
// tb_accum_stage
//
// Self-checking bench for accum_stage (BURST_LEN = 4). Directed scenarios
// cover reset, plain bursts, wrap/saturation, short bursts, backpressure with
// a stalled producer, mid-burst reset and back-to-back bursts; a randomized
// phase then runs against a reference model that works on the plain integer
// total of each burst.
// -----------------------------------------------------------------------------
module tb_accum_stage;

  localparam int BL = 4;
  localparam int CW = $clog2(BL + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_data = 4'd0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    out_sum;
  logic          out_ovf;
  logic [CW-1:0] out_cnt;

  accum_stage #(.BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: integer total per burst, result queue.
  // ---------------------------------------------------------------------------
  typedef struct {
    int sum;
    int ovf;
    int cnt;
  } res_t;

  res_t exp_q[$];
  int   m_total      = 0;
  int   m_cnt        = 0;
  int   last_acc_cyc = -10;
  int   prev_pop     = -100;
  int   last_pop     = -100;
  bit   prev_ov      = 1'b0;
  bit   rnd_bp       = 1'b0;

  function automatic res_t make_result(input int total, input int cnt);
    res_t r;
    r.ovf = (total > 15) ? 1 : 0;
`ifdef ACCUM_SATURATE_EN
    r.sum = (total > 15) ? 15 : total;
`else
    r.sum = total % 16;
`endif
    r.cnt = cnt;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_total = 0;
      m_cnt   = 0;
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        check("ready_while_valid", in_ready, 0);
        if (!prev_ov) check("latency", cyc - last_acc_cyc, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("sum", out_sum, exp_q[0].sum);
          check("ovf", out_ovf, exp_q[0].ovf);
          check("cnt", out_cnt, exp_q[0].cnt);
          if (out_ready) begin
            void'(exp_q.pop_front());
            prev_pop = last_pop;
            last_pop = cyc;
          end
        end
      end
      if (in_valid && in_ready) begin
        m_total += int'(in_data);
        m_cnt++;
        last_acc_cyc = cyc;
        if (in_last || m_cnt == BL) begin
          exp_q.push_back(make_result(m_total, m_cnt));
          m_total = 0;
          m_cnt   = 0;
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge).
  // ---------------------------------------------------------------------------
  task automatic put(input logic [3:0] d, input bit last);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 50) begin
        check("put_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset state.
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_cnt", out_cnt, 0);
    #2 rst = 1'b0;
    #1 check("ready_before_clk", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_after_clk", in_ready, 1);
    @(posedge clk);
    #1;

    // 1, 1, 6, 5 -> 13.
    out_ready = 1'b1;
    put(4'd1, 0); put(4'd1, 0); put(4'd6, 0); put(4'd5, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("basic_valid", out_valid, 1);
    check("basic_sum", out_sum, 13);
    check("basic_ovf", out_ovf, 0);
    check("basic_cnt", out_cnt, 4);
    @(posedge clk);
    #1;

    // 15, 1, 0, 0 -> wrap or saturate.
    put(4'd15, 0); put(4'd1, 0); put(4'd0, 0); put(4'd0, 0);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef ACCUM_SATURATE_EN
    check("wrap_sum", out_sum, 15);
`else
    check("wrap_sum", out_sum, 0);
`endif
    check("wrap_ovf", out_ovf, 1);
    @(posedge clk);
    #1;

    // Short burst 6, 5(last) -> 11, then a single-operand burst from zero.
    put(4'd6, 0); put(4'd5, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("short_sum", out_sum, 11);
    check("short_cnt", out_cnt, 2);
    check("short_ovf", out_ovf, 0);
    @(posedge clk);
    #1;
    put(4'd2, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("single_sum", out_sum, 2);
    check("single_cnt", out_cnt, 1);
    @(posedge clk);
    #1;

    // Backpressure: result 10 held while the producer stalls with data 3.
    out_ready = 1'b0;
    put(4'd10, 0); put(4'd0, 0); put(4'd0, 0); put(4'd0, 0);
    in_valid = 1'b1;
    in_data  = 4'd3;
    in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_sum", out_sum, 10);
      check("stall_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("turnaround_ready", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("restart_ready", in_ready, 1);
    @(posedge clk);
    #1;
    put(4'd1, 0); put(4'd1, 0); put(4'd1, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("restart_sum", out_sum, 6);
    @(posedge clk);
    #1;

    // Reset mid-burst discards the partial sum immediately.
    put(4'd9, 0); put(4'd6, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", out_sum, 0);
    check("midrst_cnt", out_cnt, 0);
    check("midrst_ready", in_ready, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    put(4'd1, 0); put(4'd2, 0); put(4'd3, 0); put(4'd4, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("postrst_sum", out_sum, 10);
    check("postrst_cnt", out_cnt, 4);
    @(posedge clk);
    #1;

    // Back-to-back bursts with out_ready held high: results 5 cycles apart.
    put(4'd9, 0); put(4'd6, 0); put(4'd1, 0); put(4'd1, 0);
    put(4'd10, 0); put(4'd5, 0); put(4'd0, 0); put(4'd1, 0);
    idle(2);
    check("b2b_period", last_pop - prev_pop, 5);

    // Randomized phase with random backpressure.
    rnd_bp = 1'b1;
    repeat (200) begin
      put(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rnd_bp    = 1'b0;
    out_ready = 1'b1;
    // Close any open burst so the model and DUT both drain.
    put(4'd0, 1);
    idle(10);
    check("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_stage.md
# accum_stage

Sequential accumulation stage that sits directly downstream of the 4-bit carry adder. It accepts a stream of 4-bit operands over a valid/ready handshake and folds each one into a running sum using the same modulo-16 addition the adder computes (S = A + B, carry-out discarded from the sum). After BURST_LEN operands, or earlier if `in_last` is asserted, it presents the sum and a sticky overflow flag on a valid/ready output port.

## Interface
- `BURST_LEN`, default 4: operands per result, legal range 1..15.
- `CNT_W`, default $clog2(BURST_LEN+1): width of the operand counter.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  operand present on `in_data`.
- `in_ready`  out  1  stage can accept an operand this cycle.
- `in_data`  in  4  operand.
- `in_last`  in  1  qualified by `in_valid`; marks the final operand of a short burst.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_sum`  out  4  accumulated sum.
- `out_ovf`  out  1  at least one carry-out occurred during the burst.
- `out_cnt`  out  CNT_W  number of operands folded into `out_sum`.

## Operation
- The block has two states, ACC and OUT. Reset state is ACC, with acc=0, ovf=0 and cnt=0.
- Accept occurs when `in_valid && in_ready`.
- On accept:
  - {carry, acc} <= acc + in_data, computed as a 5-bit result.
  - ovf <= ovf | carry.
  - cnt <= cnt + 1.
- Burst end: the accepted operand has `in_last`=1, or cnt+1 == BURST_LEN. On burst end, the next state is OUT.
- ACC state: `in_ready`=1 and `out_valid`=0.
- OUT state:
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum`, `out_ovf` and `out_cnt` are held stable until the output handshake completes.
- Output handshake in OUT: when `out_ready`=1, acc, ovf and cnt clear to 0 and the state returns to ACC.
- `in_last` is ignored when `in_valid`=0.
- `in_last` on the first operand yields a 1-operand result.
- Operands are never dropped. `in_valid` held during OUT stalls until the state returns to ACC.
- Reset outputs: `in_ready`=0 while `rst` is high, then 1 from the first clock after release. `out_valid`=0, `out_sum`=0, `out_ovf`=0, `out_cnt`=0.

## Timing
- Throughput in ACC is one operand per cycle.
- Latency: the result is visible on `out_*` in the cycle after the last operand is accepted.
- Turnaround: in the cycle where OUT completes, `in_ready`=0, so no operand can be accepted in the same cycle as result pop. The next operand can be accepted one cycle later.
- Minimum burst period is BURST_LEN+1 cycles with no backpressure.
- All outputs come from registers or the state decode. There is no combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.
- Reset asserted mid-burst or in OUT discards the partial sum immediately. No result is emitted for that burst.
- Wrap-around: acc wraps modulo 16, and cnt never exceeds BURST_LEN.

## Configuration
- Macro: `ACCUM_SATURATE_EN`.
- Defined: on any carry-out, acc <= 4'hF, and it stays 4'hF for the rest of the burst; later adds cannot lower it. `out_ovf` is still set.
- Not defined: acc wraps modulo 16, identical to the adder's S output. `out_ovf` reports the carry.

## Test plan
- BURST_LEN=4, operands 1, 1, 6, 5 with no stalls -> `out_sum`=13, `out_ovf`=0, `out_cnt`=4, `out_valid` one cycle after the 4th accept.
- Operands 15, 1, 0, 0 -> without the macro `out_sum`=0, `out_ovf`=1; with `ACCUM_SATURATE_EN` `out_sum`=15, `out_ovf`=1.
- Operands 6, then 5 with `in_last`=1 -> `out_sum`=11, `out_cnt`=2, `out_ovf`=0. The following burst starts from acc=0.
- Result 10 (10, 0, 0, 0) with `out_ready` low for 3 cycles and `in_valid` held high with data 3 -> `out_sum` stays 10, `in_ready`=0 throughout. After the pop, 3 is accepted one cycle later and starts the next burst.
- Operands 9, 6 accepted, then `rst` pulsed mid-burst -> `out_valid`=0 and the internal sum is 0 immediately. A following burst 1, 2, 3, 4 gives `out_sum`=10, `out_cnt`=4.
- Back-to-back bursts 9, 6, 1, 1 and 10, 5, 0, 1 with `out_ready`=1 -> results 1 (ovf=1) and 0 (ovf=1). The results are exactly 5 cycles apart.
